// File: rtl/vga_capture.sv
// vga_capture: receive side of a VGA-style raster link.
//   Samples RED/GRN/BLU/HSYNC/VSYNC, recovers x/y from sync edges, and
//   presents each visible pixel with its coordinate.
//   Tracks line length and line count per frame, and asserts `locked` once
//   LOCK_FRAMES consecutive frames match. Timing errors are flagged with a pulse.
//   Pipeline: input register -> counter/edge stage -> output register.
//   A pixel sampled at clock n is presented after clock n+2.
// Optional feature: define VGA_CAPTURE_CHK_EN to build the per-frame checksum.
//   Without it, frame_chk is tied to zero.
// Ports:
//   clk          pixel clock
//   rst          asynchronous reset, active low
//   RED/GRN/BLU  incoming colour channels (8b each)
//   HSYNC/VSYNC  incoming syncs; active level set by SYNC_POL (1 = high)
//   x, y         coordinate of px_data (0 when px_valid=0)
//   px_data      {RED,GRN,BLU} of the presented pixel
//   px_valid     px_data/x/y hold a visible pixel
//   frame_start  one-cycle pulse alongside pixel (0,0)
//   locked       raster stable for LOCK_FRAMES frames
//   timing_err   one-cycle pulse on line-length / line-count mismatch or sync loss
//   frame_chk    checksum of the last complete frame
module vga_capture #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int H_BACK      = 88,
  parameter int V_BACK      = 23,
  parameter int SYNC_POL    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  RED,
  input  logic [7:0]  GRN,
  input  logic [7:0]  BLU,
  input  logic        HSYNC,
  input  logic        VSYNC,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [23:0] px_data,
  output logic        px_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [23:0] frame_chk
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] CNT_MAX = '1;
  localparam logic [10:0] H_LO    = 11'(H_BACK);
  localparam logic [10:0] H_HI    = 11'(H_BACK + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_BACK + 1);
  localparam logic [10:0] V_HI    = 11'(V_BACK + 1 + V_ACTIVE);
  localparam logic [4:0]  LOCK_N  = 5'(LOCK_FRAMES);

  // Syncs are normalised to active-high before the first register,
  // so all later logic is polarity independent.
  logic hs_in, vs_in;
  assign hs_in = (SYNC_POL != 0) ? HSYNC : ~HSYNC;
  assign vs_in = (SYNC_POL != 0) ? VSYNC : ~VSYNC;

  logic [23:0] s1_pix, p_pix;
  logic        s1_hs, s1_vs, s2_hs, s2_vs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_pix <= '0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      p_pix  <= '0;
    end else begin
      s1_pix <= {RED, GRN, BLU};
      s1_hs  <= hs_in;
      s1_vs  <= vs_in;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      p_pix  <= s1_pix;
    end
  end

  logic hs_lead, hs_trail, vs_lead, vs_trail;
  assign hs_lead  =  s1_hs & ~s2_hs;
  assign hs_trail = ~s1_hs &  s2_hs;
  assign vs_lead  =  s1_vs & ~s2_vs;
  assign vs_trail = ~s1_vs &  s2_vs;

  // hcnt/vcnt: raster position
  // lcnt: clocks since last HSYNC leading edge
  // fcnt: HSYNC leading edges since last VSYNC leading edge
  logic [10:0] hcnt, vcnt, lcnt, fcnt, line_len;
  logic [10:0] hcnt_nxt, vcnt_nxt, vcnt_base, lcnt_nxt, fcnt_nxt;
  logic [10:0] meas_len, cur_len;

  always_comb begin
    hcnt_nxt = hcnt;
    if (hs_trail) hcnt_nxt = '0;
    else if (hcnt != CNT_MAX) hcnt_nxt = hcnt + 11'd1;

    // VSYNC clear is applied before the HSYNC increment of the same clock.
    vcnt_base = vs_trail ? '0 : vcnt;
    vcnt_nxt  = vcnt_base;
    if (hs_trail && (vcnt_base != CNT_MAX)) vcnt_nxt = vcnt_base + 11'd1;

    lcnt_nxt = lcnt;
    if (hs_lead) lcnt_nxt = '0;
    else if (lcnt != CNT_MAX) lcnt_nxt = lcnt + 11'd1;

    meas_len = (lcnt == CNT_MAX) ? CNT_MAX : lcnt + 11'd1;
    cur_len  = hs_lead ? meas_len : line_len;

    fcnt_nxt = fcnt;
    if (vs_lead) fcnt_nxt = {10'd0, hs_lead};
    else if (hs_lead && (fcnt != CNT_MAX)) fcnt_nxt = fcnt + 11'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt     <= '0;
      vcnt     <= '0;
      lcnt     <= '0;
      fcnt     <= '0;
      line_len <= '0;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
      lcnt <= lcnt_nxt;
      fcnt <= fcnt_nxt;
      if (hs_lead) line_len <= meas_len;
    end
  end

  state_t      state, state_nxt;
  logic [3:0]  lock_cnt, lock_nxt;
  logic [10:0] ref_len, ref_len_nxt, ref_lines, ref_lines_nxt;
  logic        have_ref, have_ref_nxt;
  logic        err, sync_lost, same_raster;

  assign sync_lost   = (hcnt == CNT_MAX) && !hs_trail;
  assign same_raster = (cur_len == ref_len) && (fcnt == ref_lines);

  always_comb begin
    state_nxt     = state;
    lock_nxt      = lock_cnt;
    ref_len_nxt   = ref_len;
    ref_lines_nxt = ref_lines;
    have_ref_nxt  = have_ref;
    err           = 1'b0;
    case (state)
      SEARCH: begin
        lock_nxt     = '0;
        have_ref_nxt = 1'b0;
        if (vs_trail) state_nxt = TRACK;
      end
      TRACK: begin
        if (sync_lost) begin
          state_nxt = SEARCH;
          lock_nxt  = '0;
        end else if (vs_lead) begin
          // The reference always follows the latest frame, so a changed
          // raster can still lock after LOCK_FRAMES matching frames.
          ref_len_nxt   = cur_len;
          ref_lines_nxt = fcnt;
          have_ref_nxt  = 1'b1;
          if (have_ref) begin
            if (same_raster) begin
              if (lock_cnt != 4'hF) lock_nxt = lock_cnt + 4'd1;
              if (({1'b0, lock_cnt} + 5'd1) >= LOCK_N) state_nxt = LOCKED;
            end else begin
              lock_nxt = '0;
            end
          end
        end
      end
      LOCKED: begin
        if (sync_lost) begin
          state_nxt = SEARCH;
          lock_nxt  = '0;
          err       = 1'b1;
        end else if ((hs_lead && (meas_len != ref_len)) ||
                     (vs_lead && (fcnt != ref_lines))) begin
          state_nxt = TRACK;
          lock_nxt  = '0;
          err       = 1'b1;
        end
      end
      default: begin
        state_nxt = SEARCH;
        lock_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      lock_cnt  <= '0;
      ref_len   <= '0;
      ref_lines <= '0;
      have_ref  <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_cnt  <= lock_nxt;
      ref_len   <= ref_len_nxt;
      ref_lines <= ref_lines_nxt;
      have_ref  <= have_ref_nxt;
    end
  end

  assign locked = (state == LOCKED);

  logic vis;
  assign vis = (state != SEARCH) &&
               (hcnt >= H_LO) && (hcnt < H_HI) &&
               (vcnt >= V_LO) && (vcnt < V_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_valid    <= 1'b0;
      px_data     <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      px_valid    <= vis;
      px_data     <= p_pix;
      x           <= vis ? hcnt - H_LO : '0;
      y           <= vis ? vcnt - V_LO : '0;
      frame_start <= vis && (hcnt == H_LO) && (vcnt == V_LO);
      timing_err  <= err;
    end
  end

`ifdef VGA_CAPTURE_CHK_EN
  logic [23:0] chk;
  logic        chk_ok;

  // chk_ok marks that accumulation started at a VSYNC trailing edge.
  // A frame picked up mid-way is therefore never published.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk       <= '0;
      chk_ok    <= 1'b0;
      frame_chk <= '0;
    end else begin
      if (vs_trail) begin
        chk    <= '0;
        chk_ok <= 1'b1;
      end else if (vis) begin
        chk <= {chk[22:0], chk[23]} ^ p_pix;
      end
      if (vs_lead) begin
        if (chk_ok) frame_chk <= chk;
        chk_ok <= 1'b0;
      end
    end
  end
`else
  assign frame_chk = '0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
module tb_vga_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] r, g, b;
  logic       hs, vs;

  logic [10:0] x_p, y_p, x_n, y_n;
  logic [23:0] d_p, d_n, chk_p, chk_n;
  logic        v_p, v_n, fs_p, fs_n, lk_p, lk_n, te_p, te_n;

  always #5 clk = ~clk;

  vga_capture #(.H_ACTIVE(16), .V_ACTIVE(4), .H_BACK(4), .V_BACK(2),
                .SYNC_POL(1), .LOCK_FRAMES(2)) dut_p (
    .clk(clk), .rst(rst), .RED(r), .GRN(g), .BLU(b), .HSYNC(hs), .VSYNC(vs),
    .x(x_p), .y(y_p), .px_data(d_p), .px_valid(v_p), .frame_start(fs_p),
    .locked(lk_p), .timing_err(te_p), .frame_chk(chk_p));

  vga_capture #(.H_ACTIVE(16), .V_ACTIVE(4), .H_BACK(4), .V_BACK(2),
                .SYNC_POL(0), .LOCK_FRAMES(2)) dut_n (
    .clk(clk), .rst(rst), .RED(r), .GRN(g), .BLU(b), .HSYNC(~hs), .VSYNC(~vs),
    .x(x_n), .y(y_n), .px_data(d_n), .px_valid(v_n), .frame_start(fs_n),
    .locked(lk_n), .timing_err(te_n), .frame_chk(chk_n));

  typedef struct {
    int          v;
    int          h;
    logic [23:0] col;
    bit          valid;
    int          ex;
    int          ey;
    bit          fs;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  int errors = 0;
  int checks = 0;
  bit tbl_on = 0;
  bit uniform = 0;
  int hv0 = -1, hh0 = -1, hv1 = -1, hh1 = -1, hv2 = -1, hh2 = -1;
  int te_cnt_p = 0, te_cnt_n = 0, fs_cnt_p = 0, fs_cnt_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix_color(input int v, input int h);
    if (uniform) return 24'h000001;
    for (int i = 0; i < NV; i++)
      if (vecs[i].v == v && vecs[i].h == h) return vecs[i].col;
    return {8'h40 + 8'(v), 8'(h), 8'h3C};
  endfunction

  // Drive raster position (v,h) for one clock.
  // Then compare the outputs for the sample taken two clocks earlier.
  task automatic drive_px(input int v, input int h);
    logic [23:0] c;
    hs = (h < 4);
    vs = (v == 0);
    c  = pix_color(v, h);
    {r, g, b} = c;
    @(posedge clk);
    #1;
    hv2 = hv1; hh2 = hh1;
    hv1 = hv0; hh1 = hh0;
    hv0 = v;   hh0 = h;
    te_cnt_p += int'(te_p);
    te_cnt_n += int'(te_n);
    fs_cnt_p += int'(fs_p);
    fs_cnt_n += int'(fs_n);
    if (tbl_on) begin
      for (int i = 0; i < NV; i++) begin
        if (vecs[i].v == hv2 && vecs[i].h == hh2) begin
          check($sformatf("vec%0d_valid", i), {v_p, v_n}, {vecs[i].valid, vecs[i].valid});
          check($sformatf("vec%0d_x", i), {x_p, x_n}, {11'(vecs[i].ex), 11'(vecs[i].ex)});
          check($sformatf("vec%0d_y", i), {y_p, y_n}, {11'(vecs[i].ey), 11'(vecs[i].ey)});
          check($sformatf("vec%0d_fs", i), {fs_p, fs_n}, {vecs[i].fs, vecs[i].fs});
          if (vecs[i].valid)
            check($sformatf("vec%0d_data", i), {d_p, d_n}, {vecs[i].col, vecs[i].col});
        end
      end
    end
  endtask

  task automatic run_line(input int v, input int h_from, input int len);
    for (int h = h_from; h < len; h++) drive_px(v, h);
  endtask

  task automatic run_frame(input int bad_v);
    for (int v = 0; v < 8; v++) run_line(v, 0, (v == bad_v) ? 29 : 28);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_xy"}, {x_p, y_p, x_n, y_n}, 64'd0);
    check({tag, "_data"}, {d_p, d_n}, 64'd0);
    check({tag, "_flags"}, {v_p, fs_p, lk_p, te_p, v_n, fs_n, lk_n, te_n}, 64'd0);
    check({tag, "_chk"}, {chk_p, chk_n}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] exp_chk;

    vecs[0] = '{3,  8, 24'h112233, 1'b1,  0, 0, 1'b1};
    vecs[1] = '{3,  9, 24'h445566, 1'b1,  1, 0, 1'b0};
    vecs[2] = '{5, 11, 24'hA5C3E1, 1'b1,  3, 2, 1'b0};
    vecs[3] = '{4,  8, 24'h778899, 1'b1,  0, 1, 1'b0};
    vecs[4] = '{6, 23, 24'hFEDCBA, 1'b1, 15, 3, 1'b0};
    vecs[5] = '{6, 24, 24'h0F0F0F, 1'b0,  0, 0, 1'b0};
    vecs[6] = '{3,  7, 24'h123456, 1'b0,  0, 0, 1'b0};
    vecs[7] = '{2,  8, 24'h654321, 1'b0,  0, 0, 1'b0};
    vecs[8] = '{7,  8, 24'hABCDEF, 1'b0,  0, 0, 1'b0};

    exp_chk = '0;
`ifdef VGA_CAPTURE_CHK_EN
    for (int i = 0; i < 64; i++) exp_chk = {exp_chk[22:0], exp_chk[23]} ^ 24'h000001;
`endif

    rst = 1'b0;
    hs = 1'b0; vs = 1'b0; r = '0; g = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // Frames 0..2: no lock yet; frame 1 carries the vector table.
    run_frame(-1);
    check("lock_f0", {lk_p, lk_n}, 2'b00);
    tbl_on = 1; fs_cnt_p = 0; fs_cnt_n = 0;
    run_frame(-1);
    tbl_on = 0;
    check("fs_count", {fs_cnt_p[7:0], fs_cnt_n[7:0]}, {8'd1, 8'd1});
    check("lock_f1", {lk_p, lk_n}, 2'b00);
    run_frame(-1);
    check("lock_f2", {lk_p, lk_n}, 2'b00);

    // Frame 3: lock appears one clock after the VSYNC leading edge is sampled.
    drive_px(0, 0);
    check("lock_f3_before", {lk_p, lk_n}, 2'b00);
    drive_px(0, 1);
    check("lock_f3_after", {lk_p, lk_n}, 2'b11);
    run_line(0, 2, 28);
    for (int v = 1; v < 8; v++) run_line(v, 0, 28);
    check("no_err_yet", {te_cnt_p[7:0], te_cnt_n[7:0]}, 16'd0);

    // Frame 4: line 4 is 29 clocks; error is seen at line 5's leading edge.
    for (int v = 0; v < 5; v++) run_line(v, 0, (v == 4) ? 29 : 28);
    check("lock_pre_err", {lk_p, lk_n}, 2'b11);
    drive_px(5, 0);
    check("err_t0", {te_p, te_n, lk_p, lk_n}, 4'b0011);
    drive_px(5, 1);
    check("err_t1", {te_p, te_n, lk_p, lk_n}, 4'b1100);
    drive_px(5, 2);
    check("err_t2", {te_p, te_n}, 2'b00);
    run_line(5, 3, 28);
    run_line(6, 0, 28);
    run_line(7, 0, 28);

    // Frames 5 and 6: relock at the second VSYNC leading edge after the error.
    drive_px(0, 0);
    drive_px(0, 1);
    check("relock_f5", {lk_p, lk_n}, 2'b00);
    run_line(0, 2, 28);
    for (int v = 1; v < 8; v++) run_line(v, 0, 28);
    drive_px(0, 0);
    drive_px(0, 1);
    check("relock_f6", {lk_p, lk_n}, 2'b11);
    run_line(0, 2, 28);
    for (int v = 1; v < 8; v++) run_line(v, 0, 28);
    check("err_single", {te_cnt_p[7:0], te_cnt_n[7:0]}, {8'd1, 8'd1});

    // Mid-line asynchronous reset while a visible pixel is being presented.
    for (int v = 0; v < 3; v++) run_line(v, 0, 28);
    run_line(3, 0, 12);
    check("pre_rst_valid", {v_p, v_n, lk_p, lk_n}, 4'b1111);
    #2;
    rst = 1'b0;
    #1;
    check_zero("midrst");
    hs = 1'b0; vs = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    hv0 = -1; hh0 = -1; hv1 = -1; hh1 = -1; hv2 = -1; hh2 = -1;

    // Uniform frames for the checksum; lock sequence repeats after reset.
    uniform = 1;
    run_frame(-1);
    check("chk_g0", {chk_p, chk_n}, 48'd0);
    check("lock_g0", {lk_p, lk_n}, 2'b00);
    drive_px(0, 0);
    drive_px(0, 1);
    check("chk_g1", {chk_p, chk_n}, {exp_chk, exp_chk});
    run_line(0, 2, 28);
    for (int v = 1; v < 8; v++) run_line(v, 0, 28);
    check("lock_g1", {lk_p, lk_n}, 2'b00);
    drive_px(0, 0);
    drive_px(0, 1);
    check("chk_g2", {chk_p, chk_n}, {exp_chk, exp_chk});
    run_line(0, 2, 28);
    for (int v = 1; v < 8; v++) run_line(v, 0, 28);
    check("lock_g2", {lk_p, lk_n}, 2'b00);
    drive_px(0, 0);
    drive_px(0, 1);
    check("lock_g3", {lk_p, lk_n}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
